prefetch_unit: RTL and testbench
================================

PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 16, PC width in bits.
REQ-002 The block SHALL take parameter INSTR_W, default 16, instruction width in bits.
REQ-003 The block SHALL take parameter DEPTH, default 4, prefetch queue entries, power of two and at least 2.
REQ-004 The block SHALL take parameter PC_STEP, default 2, sequential PC increment.
REQ-005 The block SHALL take parameter RESET_PC, default 0, first fetch address.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-008 The block SHALL have port redirect, input, 1, taken branch, jump or immediate-PC event.
REQ-009 The block SHALL have port redirect_pc, input, ADDR_W, target of the redirect.
REQ-010 The block SHALL have port halt, input, 1, stop issuing new fetches.
REQ-011 The block SHALL have port out_ready, input, 1, decode accepts the head entry.
REQ-012 The block SHALL have port out_valid, output, 1, head entry valid (inverse of nop).
REQ-013 The block SHALL have port out_instr, output, INSTR_W, head instruction.
REQ-014 The block SHALL have port out_pc_inc, output, ADDR_W, head PC plus PC_STEP.
REQ-015 The block SHALL have port imem_addr, output, ADDR_W, fetch address.
REQ-016 The block SHALL have port imem_rd, output, 1, read request.
REQ-017 The block SHALL have ports imem_data (input, INSTR_W, read data), imem_done (input, 1, read complete) and imem_err (input, 1, memory error).
REQ-018 The block SHALL have port err, output, 1, sticky error.

Function
REQ-019 FSM states SHALL be IDLE, REQ, DROP and HALTED.
REQ-020 In IDLE the block SHALL enter REQ when halt=0 and queue count + 0 < DEPTH; one request outstanding at most.
REQ-021 In REQ and DROP, imem_rd SHALL be 1 and imem_addr SHALL be held stable until imem_done; otherwise imem_rd=0.
REQ-022 When imem_done arrives in REQ, {imem_data, addr+PC_STEP} SHALL be pushed, fetch PC SHALL advance by PC_STEP modulo 2^ADDR_W, and the FSM SHALL return to IDLE.
REQ-023 A REQ whose imem_done arrives in the same cycle as issue eligibility SHALL allow the next request on the following cycle: one fetch per two cycles minimum.
REQ-024 A redirect SHALL flush the queue (out_valid=0 next cycle) and load fetch PC with redirect_pc.
REQ-025 A redirect during REQ without imem_done SHALL move the FSM to DROP; the response SHALL be discarded and the FSM SHALL go to IDLE.
REQ-026 A redirect in the same cycle as imem_done SHALL win: data dropped, FSM to IDLE.
REQ-027 A redirect in the same cycle as a pop SHALL win: the queue ends empty.
REQ-028 Pop SHALL occur on out_valid & out_ready; a simultaneous push and pop SHALL leave the count unchanged.
REQ-029 Issue SHALL be gated so the queue never overflows; a push into a full queue SHALL be impossible by construction.
REQ-030 Pointers SHALL wrap modulo DEPTH.
REQ-031 halt=1 in IDLE SHALL enter HALTED; an in-flight request SHALL complete and push first; the queue SHALL still drain.
REQ-032 HALTED SHALL be left only on redirect (to IDLE with the new PC) or reset.
REQ-033 imem_err=1 SHALL set err, which SHALL stay 1 until reset.

Reset
REQ-034 While rst=1 the block SHALL drive: state IDLE, fetch PC RESET_PC, queue empty, out_valid 0, imem_rd 0, err 0, out_instr and out_pc_inc 0.
REQ-035 Reset mid-request SHALL abandon the request without a push; the first request SHALL issue in the cycle after rst falls.

Structure
REQ-036 FSM state encoding and the PC_STEP/RESET_PC defaults SHALL live in the shared fetch package.
REQ-037 The queue SHALL be a sub-module fifo_sync parametrised by width (INSTR_W+ADDR_W), depth and flush input.

Verification
REQ-038 Reset release, 1-cycle memory, out_ready=1: imem_addr SHALL sequence 0,2,4,6; out_pc_inc SHALL be 2,4,6,8 in order.
REQ-039 out_ready=0, DEPTH=4: after 4 pushes imem_rd SHALL stay 0; one pop SHALL trigger a fetch of 0x0008.
REQ-040 Redirect to 0x0100 while a 3-cycle read of 0x0004 is pending: the 0x0004 data SHALL never appear; the next imem_addr SHALL be 0x0100.
REQ-041 redirect and imem_done in the same cycle with the queue holding 2 entries: out_valid=0 next cycle; count 0.
REQ-042 halt with a pending read: that entry is pushed, no further imem_rd, and the queue drains to empty; a redirect to 0x0020 resumes at 0x0020.
REQ-043 Fetch PC 0xFFFE with ADDR_W=16: the next address SHALL be 0x0000; an imem_err pulse SHALL hold err=1 until rst.

Source files
------------

// File: rtl/prefetch_unit_pkg.sv
// Shared fetch package: FSM state encoding and default fetch parameters.
package prefetch_unit_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,  // waiting for queue space / halt / redirect
        ST_REQ    = 2'd1,  // read outstanding, response will be kept
        ST_DROP   = 2'd2,  // read outstanding, response will be discarded
        ST_HALTED = 2'd3   // no new fetches until a redirect
    } fetch_state_t;

    localparam int DEF_PC_STEP  = 2;
    localparam int DEF_RESET_PC = 0;

endpackage

// File: rtl/prefetch_unit_fifo_sync.sv
// Small synchronous queue with flush; head entry readable without a pop.
module fifo_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             push_ok;
    logic             pop_ok;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;
    assign head_data = mem[rd_ptr_reg];

    // Occupancy follows push/pop; a simultaneous push and pop cancel out.
    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // Storage write; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; flush empties the queue.
    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: one outstanding memory read, results queued for decode.
module prefetch_unit
    import prefetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = DEF_PC_STEP,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc_inc,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_rd,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_done,
    input  logic               imem_err,
    output logic               err
);

    localparam int                ENTRY_W = INSTR_W + ADDR_W;
    localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(PC_STEP);

    fetch_state_t        state_reg;
    fetch_state_t        state_next;
    logic [ADDR_W-1:0]   fetch_pc_reg;
    logic [ADDR_W-1:0]   fetch_pc_next;
    logic [ADDR_W-1:0]   req_addr_reg;
    logic [ADDR_W-1:0]   req_addr_next;
    logic                err_reg;
    logic                q_push;
    logic                q_pop;
    logic                q_empty;
    logic                q_full;
    logic [ENTRY_W-1:0]  q_push_data;
    logic [ENTRY_W-1:0]  q_head;

    // Each entry carries the instruction and the address following it.
    assign q_push_data = {imem_data, req_addr_reg + PC_INC};

    fifo_sync #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .srst      (rst),
        .flush     (redirect),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .head_data (q_head),
        .empty     (q_empty),
        .full      (q_full)
    );

    assign out_valid  = ~q_empty & ~rst;
    assign q_pop      = out_valid & out_ready;
    assign out_instr  = out_valid ? q_head[ENTRY_W-1 -: INSTR_W] : '0;
    assign out_pc_inc = out_valid ? q_head[ADDR_W-1:0] : '0;
    assign imem_addr  = req_addr_reg;
    assign imem_rd    = ~rst & ((state_reg == ST_REQ) || (state_reg == ST_DROP));
    assign err        = err_reg & ~rst;

    // Next-state logic; a redirect always wins over responses, pops and halt.
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        req_addr_next = req_addr_reg;
        q_push        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (redirect) begin
                    fetch_pc_next = redirect_pc;
                end else if (halt) begin
                    state_next = ST_HALTED;
                end else if (!q_full) begin
                    // Issue only when the queue has room for the response.
                    state_next    = ST_REQ;
                    req_addr_next = fetch_pc_reg;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    fetch_pc_next = redirect_pc;
                    state_next    = imem_done ? ST_IDLE : ST_DROP;
                end else if (imem_done) begin
                    q_push        = 1'b1;
                    fetch_pc_next = fetch_pc_reg + PC_INC;
                    state_next    = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (redirect) begin
                    fetch_pc_next = redirect_pc;
                end
                if (imem_done) begin
                    state_next = ST_IDLE;
                end
            end
            ST_HALTED: begin
                if (redirect) begin
                    fetch_pc_next = redirect_pc;
                    state_next    = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, PC and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            fetch_pc_reg <= RESET_PC;
            req_addr_reg <= RESET_PC;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            req_addr_reg <= req_addr_next;
            if (imem_err) begin
                err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prefetch_unit.sv
// Self-checking bench for prefetch_unit: directed scenarios plus randomized traffic
// checked against an instruction-stream reference model.
module tb_prefetch_unit;

    localparam int AW    = 16;
    localparam int IW    = 16;
    localparam int DEPTH = 4;
    localparam int STEP  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          halt = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_pc_inc;
    logic [AW-1:0] imem_addr;
    logic          imem_rd;
    logic [IW-1:0] imem_data = '0;
    logic          imem_done = 1'b0;
    logic          imem_err = 1'b0;
    logic          err;

    always #5 clk = ~clk;

    prefetch_unit #(
        .ADDR_W   (AW),
        .INSTR_W  (IW),
        .DEPTH    (DEPTH),
        .PC_STEP  (STEP),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc_inc  (out_pc_inc),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .imem_data   (imem_data),
        .imem_done   (imem_done),
        .imem_err    (imem_err),
        .err         (err)
    );

    int            n_checks = 0;
    int            n_pass = 0;
    int            mem_lat = 1;
    int            busy = 0;
    int            cyc = 0;
    int            viol_flush = 0;
    int            viol_addr = 0;
    logic [AW-1:0] exp_pc = '0;
    bit            prev_rd = 0;
    bit            prev_done = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [AW-1:0] iss_q[$];
    int            iss_cyc[$];
    logic [31:0]   obs_q[$];
    logic [31:0]   exp_q[$];

    // Instruction memory contents as a pure function of address.
    function automatic logic [IW-1:0] memfn(input logic [AW-1:0] a);
        return (a ^ 16'h5A3C) + {a[7:0], a[15:8]};
    endfunction

    // One clock cycle: observe the current cycle, advance the stream model,
    // cross the clock edge, then play the memory for the new cycle.
    task automatic tick();
        bit chk;
        chk = 0;
        if (rst) begin
            exp_pc    = 16'h0000;
            prev_rd   = 0;
            prev_done = 0;
        end else begin
            if (imem_rd && prev_rd && !prev_done && imem_addr !== prev_addr) viol_addr++;
            if (imem_rd && !(prev_rd && !prev_done)) begin
                iss_q.push_back(imem_addr);
                iss_cyc.push_back(cyc);
            end
            if (redirect) begin
                exp_pc = redirect_pc;
                chk    = 1;
            end else if (out_valid && out_ready) begin
                obs_q.push_back({out_pc_inc, out_instr});
                exp_q.push_back({exp_pc + 16'(STEP), memfn(exp_pc)});
                exp_pc = exp_pc + 16'(STEP);
            end
            prev_rd   = imem_rd;
            prev_done = imem_done;
            prev_addr = imem_addr;
        end
        @(negedge clk);
        cyc++;
        if (chk && out_valid) viol_flush++;
        if (rst || !imem_rd) begin
            imem_done = 0;
            busy      = 0;
        end else begin
            busy++;
            if (busy >= mem_lat) begin
                imem_done = 1;
                imem_data = memfn(imem_addr);
                busy      = 0;
            end else begin
                imem_done = 0;
            end
        end
    endtask

    task automatic clear_logs();
        iss_q.delete();
        iss_cyc.delete();
        obs_q.delete();
        exp_q.delete();
        viol_flush = 0;
        viol_addr  = 0;
    endtask

    task automatic do_reset();
        rst = 1; redirect = 0; halt = 0; out_ready = 0; imem_err = 0;
        tick();
        tick();
        rst = 0;
        clear_logs();
    endtask

    task automatic test_reset();
        rst = 1; redirect = 1; redirect_pc = 16'h1234; halt = 1; out_ready = 1; imem_err = 1;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++;
        if (imem_rd !== 1'b0) $display("FAIL reset_imem_rd got %b want 0", imem_rd); else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
        n_checks++;
        if (out_instr !== 16'h0 || out_pc_inc !== 16'h0)
            $display("FAIL reset_outputs got instr=%h pc_inc=%h want 0/0", out_instr, out_pc_inc);
        else n_pass++;
        redirect = 0; halt = 0; imem_err = 0; mem_lat = 4;
        rst = 0;
        clear_logs();
        n_checks++;
        if (imem_rd !== 1'b0) $display("FAIL release_first_cycle got rd=%b want 0", imem_rd); else n_pass++;
        tick();
        n_checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 16'h0000)
            $display("FAIL release_first_req got rd=%b addr=%h want 1/0000", imem_rd, imem_addr);
        else n_pass++;
        // Move the fetch to 0x0080 and reset while that read is still pending.
        redirect = 1; redirect_pc = 16'h0080;
        tick();
        redirect = 0;
        for (int k = 0; k < 20 && !(iss_q.size() > 0 && iss_q[iss_q.size()-1] == 16'h0080); k++) tick();
        rst = 1;
        tick();
        rst = 0;
        clear_logs();
        n_checks++;
        if (imem_rd !== 1'b0) $display("FAIL midreq_reset_rd got %b want 0", imem_rd); else n_pass++;
        tick();
        n_checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 16'h0000)
            $display("FAIL midreq_reset_req got rd=%b addr=%h want 1/0000", imem_rd, imem_addr);
        else n_pass++;
        for (int k = 0; k < 20; k++) tick();
        n_checks++;
        if (obs_q.size() == 0 || obs_q[0] !== {16'h0002, memfn(16'h0000)})
            $display("FAIL midreq_reset_first_pop got %h want %h", (obs_q.size() > 0) ? obs_q[0] : 32'hx,
                     {16'h0002, memfn(16'h0000)});
        else n_pass++;
    endtask

    task automatic test_sequential();
        do_reset();
        out_ready = 1; mem_lat = 1;
        for (int k = 0; k < 12; k++) tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (iss_q.size() <= i || iss_q[i] !== 16'(2 * i))
                $display("FAIL seq_addr[%0d] got %h want %h", i, (iss_q.size() > i) ? iss_q[i] : 16'hx, 16'(2 * i));
            else n_pass++;
            n_checks++;
            if (obs_q.size() <= i || obs_q[i] !== {16'(2 * i + 2), memfn(16'(2 * i))})
                $display("FAIL seq_pop[%0d] got %h want %h", i, (obs_q.size() > i) ? obs_q[i] : 32'hx,
                         {16'(2 * i + 2), memfn(16'(2 * i))});
            else n_pass++;
        end
        n_checks++;
        if (iss_cyc.size() < 2 || iss_cyc[1] - iss_cyc[0] != 2)
            $display("FAIL seq_issue_spacing got %0d want 2", (iss_cyc.size() > 1) ? iss_cyc[1] - iss_cyc[0] : -1);
        else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        out_ready = 0; mem_lat = 1;
        for (int k = 0; k < 20; k++) tick();
        n_checks++;
        if (iss_q.size() != DEPTH || imem_rd !== 1'b0)
            $display("FAIL full_stall got issues=%0d rd=%b want %0d/0", iss_q.size(), imem_rd, DEPTH);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b1 || out_pc_inc !== 16'h0002)
            $display("FAIL full_head got valid=%b pc_inc=%h want 1/0002", out_valid, out_pc_inc);
        else n_pass++;
        out_ready = 1;
        tick();
        out_ready = 0;
        for (int k = 0; k < 6; k++) tick();
        n_checks++;
        if (iss_q.size() != DEPTH + 1 || iss_q[DEPTH] !== 16'h0008)
            $display("FAIL full_refill got issues=%0d addr=%h want %0d/0008", iss_q.size(),
                     (iss_q.size() > DEPTH) ? iss_q[DEPTH] : 16'hx, DEPTH + 1);
        else n_pass++;
    endtask

    task automatic test_redirect_pending();
        int k;
        do_reset();
        out_ready = 1; mem_lat = 3;
        k = 0;
        while (iss_q.size() < 3 && k < 60) begin tick(); k++; end
        n_checks++;
        if (iss_q.size() < 3 || iss_q[2] !== 16'h0004)
            $display("FAIL redir_pend_wait got issues=%0d want read of 0004 pending", iss_q.size());
        else n_pass++;
        redirect = 1; redirect_pc = 16'h0100;
        tick();
        redirect = 0;
        for (int j = 0; j < 30; j++) tick();
        n_checks++;
        if (iss_q.size() < 4 || iss_q[3] !== 16'h0100)
            $display("FAIL redir_pend_next got %h want 0100", (iss_q.size() > 3) ? iss_q[3] : 16'hx);
        else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_q.size() || obs_q.size() < 4)
            $display("FAIL redir_pend_count got %0d want %0d (at least 4)", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL redir_pend_pop[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (viol_flush != 0 || viol_addr != 0)
            $display("FAIL redir_pend_protocol got flush=%0d addr=%0d want 0/0", viol_flush, viol_addr);
        else n_pass++;
    endtask

    task automatic test_redirect_done();
        int k;
        do_reset();
        out_ready = 0; mem_lat = 2;
        k = 0;
        while (!(iss_q.size() == 3 && imem_done) && k < 60) begin tick(); k++; end
        n_checks++;
        if (!(iss_q.size() == 3 && imem_done) || out_valid !== 1'b1)
            $display("FAIL redir_done_setup got issues=%0d done=%b valid=%b want 3/1/1", iss_q.size(), imem_done, out_valid);
        else n_pass++;
        redirect = 1; redirect_pc = 16'h0040;
        tick();
        redirect = 0;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL redir_done_flush got valid=%b want 0", out_valid); else n_pass++;
        for (int j = 0; j < 4; j++) tick();
        n_checks++;
        if (iss_q.size() < 4 || iss_q[3] !== 16'h0040)
            $display("FAIL redir_done_next got %h want 0040", (iss_q.size() > 3) ? iss_q[3] : 16'hx);
        else n_pass++;
        out_ready = 1;
        for (int j = 0; j < 15; j++) tick();
        n_checks++;
        if (obs_q.size() == 0 || obs_q[0][31:16] !== 16'h0042)
            $display("FAIL redir_done_first_pop got %h want 0042", (obs_q.size() > 0) ? obs_q[0][31:16] : 16'hx);
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL redir_done_pop[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_halt();
        int k;
        do_reset();
        out_ready = 0; mem_lat = 3;
        k = 0;
        while (iss_q.size() < 1 && k < 20) begin tick(); k++; end
        halt = 1;
        for (int j = 0; j < 12; j++) tick();
        n_checks++;
        if (iss_q.size() != 1 || imem_rd !== 1'b0)
            $display("FAIL halt_no_issue got issues=%0d rd=%b want 1/0", iss_q.size(), imem_rd);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b1 || out_pc_inc !== 16'h0002)
            $display("FAIL halt_inflight_push got valid=%b pc_inc=%h want 1/0002", out_valid, out_pc_inc);
        else n_pass++;
        out_ready = 1;
        for (int j = 0; j < 3; j++) tick();
        n_checks++;
        if (out_valid !== 1'b0 || imem_rd !== 1'b0)
            $display("FAIL halt_drain got valid=%b rd=%b want 0/0", out_valid, imem_rd);
        else n_pass++;
        halt = 0; redirect = 1; redirect_pc = 16'h0020;
        tick();
        redirect = 0;
        for (int j = 0; j < 12; j++) tick();
        n_checks++;
        if (iss_q.size() < 2 || iss_q[1] !== 16'h0020)
            $display("FAIL halt_resume got %h want 0020", (iss_q.size() > 1) ? iss_q[1] : 16'hx);
        else n_pass++;
        n_checks++;
        if (obs_q.size() < 2 || obs_q[1] !== {16'h0022, memfn(16'h0020)})
            $display("FAIL halt_resume_pop got %h want %h", (obs_q.size() > 1) ? obs_q[1] : 32'hx,
                     {16'h0022, memfn(16'h0020)});
        else n_pass++;
    endtask

    task automatic test_wrap_err();
        do_reset();
        out_ready = 1; mem_lat = 1;
        redirect = 1; redirect_pc = 16'hFFFE;
        tick();
        redirect = 0;
        for (int j = 0; j < 10; j++) tick();
        n_checks++;
        if (iss_q.size() < 2 || iss_q[0] !== 16'hFFFE || iss_q[1] !== 16'h0000)
            $display("FAIL wrap_addr got %h,%h want fffe,0000", (iss_q.size() > 0) ? iss_q[0] : 16'hx,
                     (iss_q.size() > 1) ? iss_q[1] : 16'hx);
        else n_pass++;
        n_checks++;
        if (obs_q.size() == 0 || obs_q[0] !== {16'h0000, memfn(16'hFFFE)})
            $display("FAIL wrap_pop got %h want %h", (obs_q.size() > 0) ? obs_q[0] : 32'hx, {16'h0000, memfn(16'hFFFE)});
        else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("FAIL err_idle got %b want 0", err); else n_pass++;
        imem_err = 1;
        tick();
        imem_err = 0;
        n_checks++;
        if (err !== 1'b1) $display("FAIL err_set got %b want 1", err); else n_pass++;
        for (int j = 0; j < 5; j++) tick();
        n_checks++;
        if (err !== 1'b1) $display("FAIL err_sticky got %b want 1", err); else n_pass++;
        rst = 1;
        tick();
        n_checks++;
        if (err !== 1'b0) $display("FAIL err_cleared got %b want 0", err); else n_pass++;
        rst = 0;
    endtask

    task automatic test_random();
        do_reset();
        halt = 0;
        for (int i = 0; i < 1500; i++) begin
            out_ready   = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 24) == 0);
            redirect_pc = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 39) == 0) halt = ~halt;
            if (!imem_rd) mem_lat = $urandom_range(1, 4);
            tick();
        end
        redirect = 0; halt = 0;
        n_checks++;
        if (obs_q.size() != exp_q.size() || obs_q.size() < 50)
            $display("FAIL rand_pop_count got %0d want %0d (at least 50)", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL rand_pop[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (viol_flush != 0) $display("FAIL rand_flush got %0d late entries want 0", viol_flush); else n_pass++;
        n_checks++;
        if (viol_addr != 0) $display("FAIL rand_addr_stable got %0d changes want 0", viol_addr); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_full();
        test_redirect_pending();
        test_redirect_done();
        test_halt();
        test_wrap_err();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
